// File: rtl/gpi_irq_ctrl.sv
// rtl/gpi_irq_ctrl.sv - 8-pin input synchroniser, debouncer, edge detector and level interrupt controller
module gpi_irq_ctrl #(
  parameter int TICK_DIV = 1000,
  parameter int DB_CNT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        wr,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  gpi,
  output logic        irq
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]    DB_LAST  = 4'(DB_CNT - 1);

  logic [PW-1:0]     pre_cnt;
  logic              tick;
  logic [7:0]        sync1;
  logic [7:0]        sync2;
  logic [7:0]        stable;
  logic [7:0]        stable_next;
  logic [7:0][3:0]   cnt;
  logic [7:0][3:0]   cnt_next;
  logic [7:0]        rise;
  logic [7:0]        fall;
  logic [7:0]        isr_set;
  logic [7:0]        isr_clr;
  logic [7:0]        ier;
  logic [15:0]       ecfg;
  logic [7:0]        isr;
  logic              wr_en;
  logic              unused_wdata;

  assign tick         = (pre_cnt == PRE_LAST);
  assign wr_en        = cs & wr;
  assign unused_wdata = ^wdata[31:16];

  // Free-running sample-tick prescaler shared by all pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // Two-flop synchroniser for the asynchronous pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
    end else begin
      sync1 <= gpi;
      sync2 <= sync1;
    end
  end

  // Per-pin debounce: a pin must disagree for DB_CNT consecutive ticks to flip
  always_comb begin
    stable_next = stable;
    cnt_next    = cnt;
    for (int i = 0; i < 8; i++) begin
      if (sync2[i] == stable[i]) begin
        cnt_next[i] = 4'd0;
      end else if (tick) begin
        if (cnt[i] >= DB_LAST) begin
          stable_next[i] = sync2[i];
          cnt_next[i]    = 4'd0;
        end else begin
          cnt_next[i] = cnt[i] + 4'd1;
        end
      end
    end
  end

  // Debounced state and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= 8'h00;
      cnt    <= '0;
    end else begin
      stable <= stable_next;
      cnt    <= cnt_next;
    end
  end

  assign rise    = stable_next & ~stable;
  assign fall    = ~stable_next & stable;
  assign isr_set = (rise & ecfg[7:0]) | (fall & ecfg[15:8]);
  assign isr_clr = (wr_en && addr == 2'd3) ? wdata[7:0] : 8'h00;

  // Control registers and pending flags; a new event outranks a same-edge clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ier  <= 8'h00;
      ecfg <= 16'h0000;
      isr  <= 8'h00;
    end else begin
      if (wr_en && addr == 2'd1) ier  <= wdata[7:0];
      if (wr_en && addr == 2'd2) ecfg <= wdata[15:0];
      isr <= (isr & ~isr_clr) | isr_set;
    end
  end

  // Zero-latency read mux
  always_comb begin
    rdata = 32'h0;
    case (addr)
      2'd0:    rdata = {24'h0, stable};
      2'd1:    rdata = {24'h0, ier};
      2'd2:    rdata = {16'h0, ecfg};
      default: rdata = {24'h0, isr};
    endcase
  end

  assign irq = |(isr & ier);

endmodule

// File: tb/tb_gpi_irq_ctrl.sv
// tb/tb_gpi_irq_ctrl.sv - scoreboard bench for gpi_irq_ctrl with directed vectors
module tb_gpi_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  gpi = 8'h00;
  logic        irq;

  gpi_irq_ctrl #(.TICK_DIV(4), .DB_CNT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .cs    (cs),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .gpi   (gpi),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_irq;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sbq[$];
  logic mon_req = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_to = 0;

  // Monitor: pops one expectation per sample request and compares
  always @(negedge clk) begin
    if (mon_req) begin
      chk_t  c;
      logic [31:0] act;
      if (sbq.size() == 0) begin
        n_total = n_total + 1;
        $display("FAIL scoreboard_empty: got sample with no expectation");
      end else begin
        c = sbq.pop_front();
        act = c.is_irq ? {31'h0, irq} : rdata;
        n_total = n_total + 1;
        if (act === c.exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
  end

  task automatic expect_rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    chk_t c;
    addr = a;
    c.is_irq = 1'b0; c.exp = e; c.name = nm;
    sbq.push_back(c);
    mon_req = 1'b1;
    @(negedge clk);
    #1 mon_req = 1'b0;
  endtask

  task automatic expect_irq(input logic e, input string nm);
    chk_t c;
    c.is_irq = 1'b1; c.exp = {31'h0, e}; c.name = nm;
    sbq.push_back(c);
    mon_req = 1'b1;
    @(negedge clk);
    #1 mon_req = 1'b0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; cs = 1'b1; wr = 1'b1;
    @(posedge clk);
    #1 cs = 1'b0; wr = 1'b0;
  endtask

  task automatic wait_reg(input logic [1:0] a, input logic [31:0] mask,
                          input logic [31:0] val, input int maxc, input string nm);
    int k;
    addr = a;
    for (k = 0; k < maxc; k++) begin
      @(posedge clk);
      #1;
      if ((rdata & mask) == val) break;
    end
    if (k == maxc) begin
      n_to = n_to + 1;
      $display("FAIL %s: timeout, got %h expected %h", nm, rdata & mask, val);
    end
  endtask

  task automatic wait_nz(input logic [1:0] a, input int maxc, input string nm);
    int k;
    addr = a;
    for (k = 0; k < maxc; k++) begin
      @(posedge clk);
      #1;
      if (rdata != 32'h0) break;
    end
    if (k == maxc) begin
      n_to = n_to + 1;
      $display("FAIL %s: timeout, got %h expected nonzero", nm, rdata);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    // Reset with pins driven high
    gpi = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    expect_rd(2'd0, 32'h0, "rst_idr");
    expect_rd(2'd1, 32'h0, "rst_ier");
    expect_rd(2'd2, 32'h0, "rst_ecfg");
    expect_rd(2'd3, 32'h0, "rst_isr");
    expect_irq(1'b0, "rst_irq");
    @(posedge clk);
    #1 reset = 1'b1;
    expect_rd(2'd0, 32'h0, "idr_after_release");
    wait_reg(2'd0, 32'hFF, 32'hFF, 40, "held_pins_debounce");
    expect_rd(2'd0, 32'hFF, "idr_held_high");
    expect_rd(2'd3, 32'h0, "isr_no_ecfg");
    gpi = 8'h00;
    wait_reg(2'd0, 32'hFF, 32'h00, 40, "pins_low");

    // Single rising event on pin 0
    bus_wr(2'd2, 32'hFFFF_0001);
    bus_wr(2'd1, 32'hFFFF_FF01);
    expect_rd(2'd2, 32'h0000_0001, "ecfg_unused_bits");
    expect_rd(2'd1, 32'h0000_0001, "ier_unused_bits");
    gpi = 8'h01;
    repeat (8) @(posedge clk);
    expect_rd(2'd0, 32'h0, "idr0_not_early");
    wait_reg(2'd0, 32'h01, 32'h01, 40, "pin0_rise");
    expect_rd(2'd3, 32'h01, "isr0_set");
    @(posedge clk);
    #1;
    expect_irq(1'b1, "irq0_high");
    bus_wr(2'd0, 32'h0000_0000);
    expect_rd(2'd0, 32'h01, "idr_write_ignored");
    bus_wr(2'd3, 32'h0000_0001);
    expect_rd(2'd3, 32'h0, "isr0_cleared");
    expect_irq(1'b0, "irq0_low");
    gpi = 8'h00;
    wait_reg(2'd0, 32'h01, 32'h00, 40, "pin0_fall");
    repeat (2) @(posedge clk);
    expect_rd(2'd3, 32'h0, "isr0_no_fall_event");

    // Glitch shorter than three ticks on pin 3
    bus_wr(2'd2, 32'h0000_FFFF);
    gpi = 8'h08;
    repeat (6) @(posedge clk);
    #1 gpi = 8'h00;
    repeat (24) @(posedge clk);
    #1;
    expect_rd(2'd0, 32'h0, "glitch_idr");
    expect_rd(2'd3, 32'h0, "glitch_isr");

    // Falling-edge only on pin 1, IER masked
    bus_wr(2'd2, 32'h0000_0200);
    bus_wr(2'd1, 32'h0);
    gpi = 8'h02;
    wait_reg(2'd0, 32'h02, 32'h02, 40, "pin1_rise");
    repeat (2) @(posedge clk);
    expect_rd(2'd3, 32'h0, "pin1_rise_ignored");
    gpi = 8'h00;
    wait_reg(2'd0, 32'h02, 32'h00, 40, "pin1_fall");
    expect_rd(2'd3, 32'h02, "pin1_fall_isr");
    @(posedge clk);
    #1;
    expect_irq(1'b0, "pin1_irq_masked");
    bus_wr(2'd1, 32'h02);
    expect_irq(1'b1, "pin1_irq_reenable");
    bus_wr(2'd3, 32'h02);
    bus_wr(2'd1, 32'h00);

    // W1C clear collides with a rising event on pin 2
    bus_wr(2'd2, 32'h0000_0004);
    expect_rd(2'd3, 32'h0, "collide_pre_isr");
    addr = 2'd3; wdata = 32'h04; cs = 1'b1; wr = 1'b1;
    gpi = 8'h04;
    for (k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (rdata[2]) break;
    end
    cs = 1'b0; wr = 1'b0;
    if (k == 40) begin
      n_to = n_to + 1;
      $display("FAIL collide_set: timeout, got %h expected 00000004", rdata);
    end
    expect_rd(2'd3, 32'h04, "collide_set_wins");
    bus_wr(2'd3, 32'h00);
    expect_rd(2'd3, 32'h04, "w1c_zero_noop");
    bus_wr(2'd3, 32'h04);
    expect_rd(2'd3, 32'h00, "collide_cleared");
    bus_wr(2'd2, 32'h0);
    gpi = 8'h00;
    wait_reg(2'd0, 32'hFF, 32'h00, 40, "pin2_fall");

    // Simultaneous events on several pins
    bus_wr(2'd2, 32'h0000_00FF);
    bus_wr(2'd1, 32'h0000_000F);
    gpi = 8'hA5;
    wait_nz(2'd3, 40, "multi_set");
    expect_rd(2'd3, 32'hA5, "multi_isr_one_edge");
    @(posedge clk);
    #1;
    expect_irq(1'b1, "multi_irq_high");
    bus_wr(2'd3, 32'h05);
    expect_rd(2'd3, 32'hA0, "multi_isr_partial_clear");
    expect_irq(1'b0, "multi_irq_low");

    // Asynchronous reset mid-operation discards everything
    #3 reset = 1'b0;
    #1;
    expect_rd(2'd0, 32'h0, "rst2_idr");
    expect_rd(2'd1, 32'h0, "rst2_ier");
    expect_rd(2'd2, 32'h0, "rst2_ecfg");
    expect_rd(2'd3, 32'h0, "rst2_isr");
    expect_irq(1'b0, "rst2_irq");
    @(posedge clk);
    #1 reset = 1'b1;
    wait_reg(2'd0, 32'hFF, 32'hA5, 40, "rst2_redebounce");
    expect_rd(2'd3, 32'h0, "rst2_isr_no_ecfg");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total + n_to);
    $finish;
  end

endmodule
